// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round sequencing control path.
package aes_ctrl_pkg;

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_FETCH,
    ARK_ISSUE,
    ARK_WAIT,
    RF_ISSUE,
    RF_WAIT,
    FINISH
  } ctrl_state_e;

endpackage

// File: rtl/ark_key_index_gen.sv
// Round counter plus up/down round-key index; direction is captured on load
// and the index saturates at the final round so it never leaves 0..NR.
module ark_key_index_gen
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NR    = NR_AES128,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dir,
  input  logic             step,
  output logic [IDX_W-1:0] key_idx,
  output logic             last_round_c,
  output logic             final_rf_c
);

  logic [IDX_W-1:0] round;
  logic             dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      round   <= '0;
      key_idx <= '0;
      dir_q   <= 1'b0;
    end else if (load) begin
      round   <= '0;
      key_idx <= dir ? IDX_W'(NR) : '0;
      dir_q   <= dir;
    end else if (step && !last_round_c) begin
      round   <= round + IDX_W'(1);
      key_idx <= dir_q ? key_idx - IDX_W'(1) : key_idx + IDX_W'(1);
    end
  end

  assign last_round_c = (round == IDX_W'(NR));
  assign final_rf_c   = (round == IDX_W'(NR - 1));

endmodule

// File: rtl/ark_round_controller.sv
// Sequences one block through AddRoundKey and the external round function
// for NR rounds, fetching each round key by index from the key store.
module ark_round_controller
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NR    = NR_AES128,
  parameter int unsigned IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic [BLOCK_W-1:0] data_in,
  output logic [BLOCK_W-1:0] data_out,
  output logic               done,
  output logic               busy,
  output logic [IDX_W-1:0]   key_idx,
  input  logic [BLOCK_W-1:0] key_in,
  output logic [BLOCK_W-1:0] ark_key,
  output logic [BLOCK_W-1:0] ark_state,
  output logic               ark_enable,
  input  logic [BLOCK_W-1:0] ark_state_out,
  input  logic               ark_done,
  output logic               rf_start,
  output logic               rf_last,
  output logic [BLOCK_W-1:0] rf_state,
  input  logic [BLOCK_W-1:0] rf_state_out,
  input  logic               rf_done
);

  ctrl_state_e state, state_n;
  block_t      working, work_n;
  logic        load, step;
  logic        last_round_c, final_rf_c;
  logic        ark_sel;

  ark_key_index_gen #(
    .NR    (NR),
    .IDX_W (IDX_W)
  ) u_idx (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .dir          (decrypt),
    .step         (step),
    .key_idx      (key_idx),
    .last_round_c (last_round_c),
    .final_rf_c   (final_rf_c)
  );

  // Next state and working-register update
  always_comb begin
    state_n = state;
    work_n  = working;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = KEY_FETCH;
          work_n  = data_in;
          load    = 1'b1;
        end
      end
      KEY_FETCH: state_n = ARK_ISSUE;
      ARK_ISSUE: state_n = ARK_WAIT;
      ARK_WAIT: begin
        if (ark_done) begin
          work_n  = ark_state_out;
          state_n = last_round_c ? FINISH : RF_ISSUE;
        end
      end
      RF_ISSUE: state_n = RF_WAIT;
      RF_WAIT: begin
        if (rf_done) begin
          work_n  = rf_state_out;
          step    = 1'b1;
          state_n = KEY_FETCH;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      working    <= '0;
      data_out   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      ark_state  <= '0;
      ark_enable <= 1'b0;
      ark_sel    <= 1'b0;
      rf_start   <= 1'b0;
      rf_last    <= 1'b0;
      rf_state   <= '0;
    end else begin
      state      <= state_n;
      working    <= work_n;
      busy       <= (state_n != IDLE) && (state_n != FINISH);
      done       <= (state == FINISH);
      ark_enable <= (state_n == ARK_ISSUE);
      ark_sel    <= (state_n == ARK_ISSUE) || (state_n == ARK_WAIT);
      rf_start   <= (state_n == RF_ISSUE);
      if (state == FINISH) begin
        data_out <= working;
      end
      if (state == KEY_FETCH) begin
        ark_state <= working;
      end
      if ((state == ARK_WAIT) && (state_n == RF_ISSUE)) begin
        rf_state <= work_n;
        rf_last  <= final_rf_c;
      end
    end
  end

  // key_in only becomes valid in ARK_ISSUE and the key store holds it while
  // key_idx is stable, so the key is passed through for the whole ARK window.
  assign ark_key = ark_sel ? key_in : '0;

endmodule

// File: tb/tb_ark_round_controller.sv
// Scoreboard bench for ark_round_controller with key-store, AddRoundKey and
// round-function models (identity stub or FIPS-197 encrypt round).
module tb_ark_round_controller;

  localparam int NR    = 10;
  localparam int IDX_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] data_out;
  logic         done, busy;
  logic [IDX_W-1:0] key_idx;
  logic [127:0] key_in = '0;
  logic [127:0] ark_key, ark_state;
  logic         ark_enable;
  logic [127:0] ark_state_out = '0;
  logic         ark_done;
  logic         rf_start, rf_last;
  logic [127:0] rf_state;
  logic [127:0] rf_state_out = '0;
  logic         rf_done;

  logic ark_done_m = 1'b0, rf_done_m = 1'b0;
  logic ark_spur = 1'b0, rf_spur = 1'b0;
  assign ark_done = ark_done_m | ark_spur;
  assign rf_done  = rf_done_m | rf_spur;

  always #5 clk = ~clk;

  ark_round_controller #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .data_in(data_in), .data_out(data_out), .done(done), .busy(busy),
    .key_idx(key_idx), .key_in(key_in),
    .ark_key(ark_key), .ark_state(ark_state), .ark_enable(ark_enable),
    .ark_state_out(ark_state_out), .ark_done(ark_done),
    .rf_start(rf_start), .rf_last(rf_last), .rf_state(rf_state),
    .rf_state_out(rf_state_out), .rf_done(rf_done)
  );

  typedef struct {
    logic [127:0] data;
    int           lat;
    int           c0;
  } exp_t;

  int           errors = 0, checks = 0, cyc = 0;
  exp_t         sb[$];
  int           kq[$];
  logic [127:0] keys [0:15];
  int           lat_tab [0:NR-1];
  bit           aes_mode = 1'b0;
  int           rf_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  // S-box from the GF(2^8) inverse (x^254) and the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq = x, inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  task automatic build_fips_keys(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pattern_keys();
    for (int i = 0; i < 16; i++) keys[i] = {16{8'(i)}};
  endtask

  // ---------------- datapath models ----------------
  always @(posedge clk) key_in <= keys[key_idx];

  always @(posedge clk) begin
    ark_done_m    <= ark_enable;
    ark_state_out <= ark_state ^ ark_key;
  end

  int           rf_cnt = 0, ri_m = 0;
  logic [127:0] rf_cap = '0, rf_in_cap = '0;
  logic         rf_last_cap = 1'b0;

  always @(posedge clk) begin
    rf_done_m <= 1'b0;
    if (rf_start) begin
      ri_m = rf_seen - 1;
      if (ri_m < 0 || ri_m >= NR) ri_m = 0;
      rf_in_cap   <= rf_state;
      rf_last_cap <= rf_last;
      rf_cap      <= aes_mode ? aes_round(rf_state, rf_last) : rf_state;
      if (lat_tab[ri_m] <= 1) begin
        rf_done_m    <= 1'b1;
        rf_state_out <= aes_mode ? aes_round(rf_state, rf_last) : rf_state;
        rf_cnt       <= 0;
      end else begin
        rf_cnt <= lat_tab[ri_m] - 1;
      end
    end else if (rf_cnt != 0) begin
      rf_cnt <= rf_cnt - 1;
      if (rf_cnt == 1) begin
        rf_done_m    <= 1'b1;
        rf_state_out <= rf_cap;
        if (busy) begin
          chk("rf_state_stable", rf_state, rf_in_cap);
          chk("rf_last_stable", 128'(rf_last), 128'(rf_last_cap));
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_ae = 1'b0, prev_rs = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   ki;
    if (rst) begin
      sb.delete();
      kq.delete();
      rf_seen   = 0;
      prev_ae   = 1'b0;
      prev_rs   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (ark_enable) begin
        chk("ark_enable_width", 128'(prev_ae), 128'(0));
        if (kq.size() == 0) fail_now("unexpected_ark_enable");
        else begin
          ki = kq.pop_front();
          chk("key_idx", 128'(key_idx), 128'(ki));
          chk("ark_key", ark_key, keys[ki]);
        end
      end
      if (rf_start) begin
        chk("rf_start_width", 128'(prev_rs), 128'(0));
        chk("rf_last", 128'(rf_last), 128'(rf_seen == NR - 1));
        chk("rf_start_count", 128'(rf_seen < NR), 128'(1));
        rf_seen++;
      end
      if (done) begin
        chk("done_width", 128'(prev_done), 128'(0));
        chk("busy_at_done", 128'(busy), 128'(0));
        chk("rf_per_block", 128'(rf_seen), 128'(NR));
        rf_seen = 0;
        if (sb.size() == 0) fail_now("unexpected_done");
        else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          chk("latency", 128'(cyc - e.c0 - 1), 128'(e.lat));
        end
      end
      prev_ae   = ark_enable;
      prev_rs   = rf_start;
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_lat(input int v);
    for (int r = 0; r < NR; r++) lat_tab[r] = v;
  endtask

  task automatic do_start(input logic [127:0] d, input logic dec, input logic [127:0] expd);
    exp_t e;
    e.lat = 4;
    for (int r = 0; r < NR; r++) e.lat += 4 + lat_tab[r];
    e.data = expd;
    e.c0   = cyc;
    data_in = d;
    decrypt = dec;
    start   = 1'b1;
    sb.push_back(e);
    for (int k = 0; k <= NR; k++) kq.push_back(dec ? NR - k : k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now({name, "_timeout"});
    @(negedge clk);
  endtask

  localparam logic [127:0] XK = {16{8'h0b}};

  initial begin
    logic [127:0] d;
    int           n, rs;
    pattern_keys();
    set_lat(1);
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_key_idx", 128'(key_idx), 128'(0));
    chk("rst_ark_enable", 128'(ark_enable), 128'(0));
    chk("rst_rf_start", 128'(rf_start), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // identity stub, encrypt then decrypt
    do_start(128'h0, 1'b0, XK);
    wait_done("enc_identity");

    ark_spur = 1'b1; rf_spur = 1'b1;
    @(negedge clk);
    ark_spur = 1'b0; rf_spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_spur_busy", 128'(busy), 128'(0));
    chk("idle_spur_data_out", data_out, XK);
    chk("idle_spur_key_idx", 128'(key_idx), 128'(NR));

    do_start(128'h0, 1'b1, XK);
    wait_done("dec_identity");

    // FIPS-197 appendix vector through the golden round model
    aes_mode = 1'b1;
    build_fips_keys(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_start(128'h3243f6a8885a308d313198a2e0370734, 1'b0,
             128'h3925841d02dc09fbdc118597196a0b32);
    wait_done("fips");
    aes_mode = 1'b0;
    pattern_keys();
    repeat (2) @(negedge clk);

    // random round-function latency, start hammered while busy
    for (int r = 0; r < NR; r++) lat_tab[r] = int'($urandom_range(1, 5));
    d = 128'h00112233445566778899aabbccddeeff;
    do_start(d, 1'b1, d ^ XK);
    n = 0;
    while (n < 400) begin
      if (done) break;
      start   = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      decrypt = 1'($urandom_range(0, 1));
      data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) fail_now("random_timeout");
    repeat (2) @(negedge clk);

    // spurious done pulses while in KEY_FETCH
    set_lat(2);
    d = 128'hdeadbeef0123456789abcdeffedcba98;
    do_start(d, 1'b0, d ^ XK);
    ark_spur = 1'b1; rf_spur = 1'b1;
    @(negedge clk);
    ark_spur = 1'b0; rf_spur = 1'b0;
    wait_done("kf_spur");

    // reset during RF_WAIT of round 5
    set_lat(5);
    do_start(128'h5555aaaa5555aaaa5555aaaa5555aaaa, 1'b0, 128'h0);
    n = 0; rs = 0;
    while (n < 400) begin
      if (rf_start) rs++;
      if (rs == 5) break;
      @(negedge clk);
      n++;
    end
    if (rs != 5) fail_now("reach_round5_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_data_out", data_out, 128'(0));
    chk("midrst_key_idx", 128'(key_idx), 128'(0));
    chk("midrst_ark_key", ark_key, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_rf_busy", 128'(busy), 128'(0));
    chk("late_rf_data_out", data_out, 128'(0));
    chk("late_rf_key_idx", 128'(key_idx), 128'(0));

    set_lat(1);
    d = 128'hcafef00d_0badc0de_11111111_80000001;
    do_start(d, 1'b0, d ^ XK);
    wait_done("after_reset");

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("kq_empty", 128'(kq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
